reg_file_param: RTL and testbench
=================================

# reg_file_param

Parametrised register file for the asynchronous processor core, successor to the fixed 16×32 `reg_sync` block. It provides configurable width, depth and read-port count, two prioritised write ports, and architectural PC/CSPR registers with a PC auto-increment. It also has a per-register busy scoreboard so operand fetch can tell when a register still has an outstanding producer. It sits between decode/issue and the datapath (ALU, multiplier).

## Interface
Parameters:
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 4, address width; depth = 2^ADDR_W; the top address (2^ADDR_W−1) aliases PC
- `NUM_RD`, 4, number of read ports (1–8)
- `BYPASS`, 1, 1 = same-cycle write-to-read forwarding, 0 = reads see stored state only
- `PC_STEP`, 4, increment applied on `pc_inc`

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `rd_addr` in NUM_RD*ADDR_W: packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- `rd_data` out NUM_RD*DATA_W: packed read data, combinational
- `rd_valid` out NUM_RD: 1 when the addressed register is not busy, or is resolved by bypass this cycle
- `write_enable`, `write_address`, `write_data` in 1 / ADDR_W / DATA_W: write port 1
- `write_enable_2`, `write_address_2`, `write_data_2` in 1 / ADDR_W / DATA_W: write port 2
- `pc_write` in 1 / `pc_update` in DATA_W: explicit PC load from the branch unit
- `pc_inc` in 1: PC += PC_STEP
- `cspr_write` in 1 / `cspr_update` in DATA_W: CSPR load
- `lock_en` in 1 / `lock_addr` in ADDR_W: mark a register busy (a producer has been issued)
- `pc` out DATA_W, `cspr` out DATA_W: registered architectural values
- `busy` out 2^ADDR_W: scoreboard vector

## Operation
- Reset (asynchronous): all GPRs, `pc`, `cspr` and `busy` are 0. With a zeroed file, `rd_data` is 0 and `rd_valid` is all-ones.
- Writes on posedge. If both ports target the same address, port 2 wins.
- A write to the top address updates `pc`.
- PC next-value priority, highest first: write port 2 to PC, write port 1 to PC, `pc_write`, `pc_inc`. `pc_inc` wraps modulo 2^DATA_W.
- A read of the top address returns `pc`.
- `cspr_write` loads `cspr`. No write port reaches CSPR.
- Scoreboard: a write with enable set clears `busy[addr]`, and `lock_en` sets `busy[lock_addr]`. If both hit the same address in one cycle, lock wins (a new producer supersedes the old one). Locking an already-busy register is legal; it stays busy.
- `BYPASS=1`: a read address matching an enabled write this cycle returns that write data (port 2 over port 1) with `rd_valid`=1. For the PC address, the bypass value follows the full PC priority.
- `BYPASS=0`: reads show stored values, and `rd_valid` = !busy.
- Writes with enable low are ignored, whatever the address or data.

## Timing
- Read latency is 0 cycles (combinational from `rd_addr` and the stored state).
- Write latency is 1 cycle: data is visible from stored state after the next rising edge. With BYPASS it is visible in the same cycle.
- `busy` and `rd_valid` change only on a rising edge, except through the bypass path.
- Reset asserted mid-operation clears state immediately, without waiting for an edge. Writes, locks and PC ops presented on the first edge after reset is released are taken normally.
- No handshake stalls inside the block. The consumer holds off issue while `rd_valid`=0.

## Structure
- Shared package `reg_file_pkg`: default DATA_W/ADDR_W, `PC_IDX` = 2^ADDR_W−1, `PC_STEP`, and a localparam for the PC priority encoding.
- Sub-module `reg_scoreboard`: busy vector set/clear logic, parameterised by ADDR_W.
- The top level holds the storage array, PC/CSPR registers and the read muxes/bypass, generated per read port.

## Test plan
- Reset, then write R0=0x2 on port 1 and R1=0x2 on port 2 in the same cycle → next cycle, read ports 0/1 on R0/R1 return 0x2/0x2, `rd_valid`=1.
- Both ports write R3 in the same cycle (port 1 = 0xAAAA, port 2 = 0x5555) → R3 = 0x5555.
- Lock R5, then write R5=0x10 two cycles later, with BYPASS=1 → `rd_valid[R5]`=0 until the write cycle, where it is 1 with data 0x10. Next cycle `busy[5]`=0. With BYPASS=0 the data appears one cycle later.
- Lock and write R6 in the same cycle → R6 is updated and `busy[6]` stays 1.
- `pc_write` (pc_update=0x100) with `pc_inc` in the same cycle → pc=0x100. Then 3 cycles of `pc_inc` → pc=0x10C. `pc_write` of 0xFFFFFFFC then `pc_inc` → 0x0. Port 1 write to R15=0x40 together with `pc_write`=0x80 → pc=0x40.
- Assert `reset` asynchronously between edges while R2=0x7 and `busy[2]`=1 → R2, pc, cspr and busy all read 0 immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_pkg : shared defaults and PC next-value source encoding. rev 1.0|
// +--------------------------------------------------------------------------+
package reg_file_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 4;
  localparam int PC_IDX      = (1 << DEF_ADDR_W) - 1;
  localparam int DEF_PC_STEP = 4;

  // PC next-value sources; the encoding order mirrors the priority order.
  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_WP1  = 3'd3,
    PC_WP2  = 3'd4
  } pc_src_e;

  function automatic pc_src_e pc_select(input logic wp2_hit, input logic wp1_hit,
                                        input logic load, input logic inc);
    if (wp2_hit)      return PC_WP2;
    else if (wp1_hit) return PC_WP1;
    else if (load)    return PC_LOAD;
    else if (inc)     return PC_INC;
    else              return PC_HOLD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_scoreboard : per-register busy bits, set by lock, cleared by writes. |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module reg_scoreboard #(
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr1_en,
  input  logic [ADDR_W-1:0]         clr1_addr,
  input  logic                      clr2_en,
  input  logic [ADDR_W-1:0]         clr2_addr,
  input  logic                      lock_en,
  input  logic [ADDR_W-1:0]         lock_addr,
  output logic [(1 << ADDR_W)-1:0]  busy
);

  localparam int DEPTH = 1 << ADDR_W;

  // A lock in the same cycle as a completing write wins: the new producer
  // supersedes the one that just retired.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (lock_en && lock_addr == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if ((clr1_en && clr1_addr == ADDR_W'(i)) ||
                 (clr2_en && clr2_addr == ADDR_W'(i)))
          busy[i] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_param : parametrised GPR file with PC/CSPR, bypass, scoreboard. |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 4,
  parameter int BYPASS  = 1,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_valid,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          write_address,
  input  logic [DATA_W-1:0]          write_data,
  input  logic                       write_enable_2,
  input  logic [ADDR_W-1:0]          write_address_2,
  input  logic [DATA_W-1:0]          write_data_2,
  input  logic                       pc_write,
  input  logic [DATA_W-1:0]          pc_update,
  input  logic                       pc_inc,
  input  logic                       cspr_write,
  input  logic [DATA_W-1:0]          cspr_update,
  input  logic                       lock_en,
  input  logic [ADDR_W-1:0]          lock_addr,
  output logic [DATA_W-1:0]          pc,
  output logic [DATA_W-1:0]          cspr,
  output logic [(1 << ADDR_W)-1:0]   busy
);

  localparam int                DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(DEPTH - 1);

  // The top address lives in the pc register, so the array stops one short.
  logic [DATA_W-1:0] regs [DEPTH-1];
  logic              wp1_pc;
  logic              wp2_pc;
  pc_src_e           pc_src;
  logic [DATA_W-1:0] pc_next;

  assign wp1_pc = write_enable   && (write_address   == PC_ADDR);
  assign wp2_pc = write_enable_2 && (write_address_2 == PC_ADDR);

  always_comb begin
    pc_src = pc_select(wp2_pc, wp1_pc, pc_write, pc_inc);
    case (pc_src)
      PC_WP2:  pc_next = write_data_2;
      PC_WP1:  pc_next = write_data;
      PC_LOAD: pc_next = pc_update;
      PC_INC:  pc_next = pc + DATA_W'(PC_STEP);
      default: pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH - 1; i++) regs[i] <= '0;
      pc   <= '0;
      cspr <= '0;
    end else begin
      if (write_enable && !wp1_pc)   regs[write_address]   <= write_data;
      if (write_enable_2 && !wp2_pc) regs[write_address_2] <= write_data_2;
      pc <= pc_next;
      if (cspr_write) cspr <= cspr_update;
    end
  end

  reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .clr1_en   (write_enable),
    .clr1_addr (write_address),
    .clr2_en   (write_enable_2),
    .clr2_addr (write_address_2),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .busy      (busy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              hit1;
    logic              hit2;
    logic              pc_hit;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign pc_hit = (addr == PC_ADDR);
    assign stored = pc_hit ? pc : regs[addr];
    assign hit1   = write_enable   && (write_address   == addr);
    assign hit2   = write_enable_2 && (write_address_2 == addr);

    if (BYPASS != 0) begin : g_byp
      // PC forwarding uses pc_next so pc_write/pc_inc are visible too.
      always_comb begin
        data  = stored;
        valid = !busy[addr];
        if (pc_hit) begin
          data  = pc_next;
          valid = hit1 || hit2 || !busy[addr];
        end else if (hit2) begin
          data  = write_data_2;
          valid = 1'b1;
        end else if (hit1) begin
          data  = write_data;
          valid = 1'b1;
        end
      end
    end else begin : g_nobyp
      assign data  = stored;
      assign valid = !busy[addr];
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
    assign rd_valid[k]                 = valid;
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_file_param : scoreboard bench, bypassing and non-bypassing DUTs.  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_reg_file_param;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR*AW-1:0] rd_addr;
  logic          we1, we2, pc_write, pc_inc, cspr_write, lock_en;
  logic [AW-1:0] wa1, wa2, lock_addr;
  logic [DW-1:0] wd1, wd2, pc_update, cspr_update;

  logic [NR*DW-1:0] data_b, data_n;
  logic [NR-1:0]    valid_b, valid_n;
  logic [DW-1:0]    pc_b, pc_n, cspr_b, cspr_n;
  logic [15:0]      busy_b, busy_n;

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .PC_STEP(4)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(data_b), .rd_valid(valid_b),
    .write_enable(we1), .write_address(wa1), .write_data(wd1),
    .write_enable_2(we2), .write_address_2(wa2), .write_data_2(wd2),
    .pc_write(pc_write), .pc_update(pc_update), .pc_inc(pc_inc),
    .cspr_write(cspr_write), .cspr_update(cspr_update),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .pc(pc_b), .cspr(cspr_b), .busy(busy_b));

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .PC_STEP(4)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(data_n), .rd_valid(valid_n),
    .write_enable(we1), .write_address(wa1), .write_data(wd1),
    .write_enable_2(we2), .write_address_2(wa2), .write_data_2(wd2),
    .pc_write(pc_write), .pc_update(pc_update), .pc_inc(pc_inc),
    .cspr_write(cspr_write), .cspr_update(cspr_update),
    .lock_en(lock_en), .lock_addr(lock_addr),
    .pc(pc_n), .cspr(cspr_n), .busy(busy_n));

  // Observation selectors for queued expectations.
  localparam int S_DATA_B = 0, S_VALID_B = 1, S_DATA_N = 2, S_VALID_N = 3;
  localparam int S_PC_B = 4, S_PC_N = 5, S_CSPR_B = 6, S_CSPR_N = 7;
  localparam int S_BUSY_B = 8, S_BUSY_N = 9;

  typedef struct {
    string       tag;
    int          sel;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] observe(input int sel, input int idx);
    case (sel)
      S_DATA_B:  return data_b[idx*DW +: DW];
      S_VALID_B: return 32'(valid_b[idx]);
      S_DATA_N:  return data_n[idx*DW +: DW];
      S_VALID_N: return 32'(valid_n[idx]);
      S_PC_B:    return pc_b;
      S_PC_N:    return pc_n;
      S_CSPR_B:  return cspr_b;
      S_CSPR_N:  return cspr_n;
      S_BUSY_B:  return 32'(busy_b[idx]);
      default:   return 32'(busy_n[idx]);
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel, input int idx, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.idx = idx; e.exp = exp;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, observe(e.sel, e.idx), e.exp);
    end
  endtask

  task automatic clear_inputs();
    we1 = 0; we2 = 0; pc_write = 0; pc_inc = 0; cspr_write = 0; lock_en = 0;
    wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; lock_addr = '0;
    pc_update = '0; cspr_update = '0;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  // Compare everything queued for the current cycle, then advance one edge.
  task automatic tick();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rd_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    for (int k = 0; k < NR; k++) begin
      expect_v("rst_data", S_DATA_N, k, 32'h0);
      expect_v("rst_valid", S_VALID_N, k, 32'h1);
      expect_v("rst_valid_b", S_VALID_B, k, 32'h1);
    end
    expect_v("rst_pc", S_PC_B, 0, 32'h0);
    expect_v("rst_cspr", S_CSPR_B, 0, 32'h0);
    for (int i = 0; i < 16; i++) expect_v("rst_busy", S_BUSY_B, i, 32'h0);
    tick();

    // Dual write R0/R1
    we1 = 1; wa1 = 4'd0; wd1 = 32'h2;
    we2 = 1; wa2 = 4'd1; wd2 = 32'h2;
    expect_v("byp_r0", S_DATA_B, 0, 32'h2);
    expect_v("byp_r1", S_DATA_B, 1, 32'h2);
    expect_v("nobyp_r0_old", S_DATA_N, 0, 32'h0);
    tick();
    expect_v("r0", S_DATA_N, 0, 32'h2);
    expect_v("r1", S_DATA_N, 1, 32'h2);
    expect_v("r0_valid", S_VALID_N, 0, 32'h1);
    expect_v("r1_valid", S_VALID_N, 1, 32'h1);
    tick();

    // Same-address collision: port 2 wins
    we1 = 1; wa1 = 4'd3; wd1 = 32'hAAAA;
    we2 = 1; wa2 = 4'd3; wd2 = 32'h5555;
    set_rd(2, 4'd3);
    expect_v("byp_r3_p2", S_DATA_B, 2, 32'h5555);
    tick();
    expect_v("r3_p2", S_DATA_N, 2, 32'h5555);
    expect_v("r3_p2_b", S_DATA_B, 2, 32'h5555);
    tick();

    // Lock R5, write two cycles later
    lock_en = 1; lock_addr = 4'd5;
    set_rd(3, 4'd5);
    expect_v("r5_pre_lock_valid", S_VALID_B, 3, 32'h1);
    tick();
    expect_v("r5_busy", S_BUSY_B, 5, 32'h1);
    expect_v("r5_valid_b", S_VALID_B, 3, 32'h0);
    expect_v("r5_valid_n", S_VALID_N, 3, 32'h0);
    tick();
    we1 = 1; wa1 = 4'd5; wd1 = 32'h10;
    expect_v("r5_byp_valid", S_VALID_B, 3, 32'h1);
    expect_v("r5_byp_data", S_DATA_B, 3, 32'h10);
    expect_v("r5_nobyp_valid", S_VALID_N, 3, 32'h0);
    tick();
    expect_v("r5_busy_clr_b", S_BUSY_B, 5, 32'h0);
    expect_v("r5_busy_clr_n", S_BUSY_N, 5, 32'h0);
    expect_v("r5_nobyp_data", S_DATA_N, 3, 32'h10);
    expect_v("r5_nobyp_valid2", S_VALID_N, 3, 32'h1);
    tick();

    // Lock and write R6 in one cycle: lock wins
    lock_en = 1; lock_addr = 4'd6;
    we1 = 1; wa1 = 4'd6; wd1 = 32'h66;
    set_rd(0, 4'd6);
    tick();
    expect_v("r6_data", S_DATA_N, 0, 32'h66);
    expect_v("r6_busy", S_BUSY_N, 6, 32'h1);
    expect_v("r6_valid_n", S_VALID_N, 0, 32'h0);
    expect_v("r6_valid_b", S_VALID_B, 0, 32'h0);
    tick();

    // PC priority and increment
    set_rd(1, 4'd15);
    pc_write = 1; pc_update = 32'h100; pc_inc = 1;
    expect_v("pc_byp_load", S_DATA_B, 1, 32'h100);
    expect_v("pc_nobyp_old", S_DATA_N, 1, 32'h0);
    tick();
    expect_v("pc_load", S_PC_B, 0, 32'h100);
    pc_inc = 1;
    tick();
    pc_inc = 1;
    tick();
    pc_inc = 1;
    tick();
    expect_v("pc_inc3", S_PC_B, 0, 32'h10C);
    expect_v("pc_inc3_rd", S_DATA_N, 1, 32'h10C);
    pc_write = 1; pc_update = 32'hFFFF_FFFC;
    tick();
    pc_inc = 1;
    tick();
    expect_v("pc_wrap", S_PC_N, 0, 32'h0);
    we1 = 1; wa1 = 4'd15; wd1 = 32'h40;
    pc_write = 1; pc_update = 32'h80;
    expect_v("pc_byp_wp1", S_DATA_B, 1, 32'h40);
    tick();
    expect_v("pc_wp1_over_load", S_PC_B, 0, 32'h40);
    we1 = 1; wa1 = 4'd15; wd1 = 32'h11;
    we2 = 1; wa2 = 4'd15; wd2 = 32'h22;
    pc_inc = 1;
    expect_v("pc_byp_wp2", S_DATA_B, 1, 32'h22);
    tick();
    expect_v("pc_wp2", S_PC_N, 0, 32'h22);
    expect_v("pc_rd_wp2", S_DATA_N, 1, 32'h22);

    // CSPR load
    cspr_write = 1; cspr_update = 32'h3C;
    tick();
    expect_v("cspr", S_CSPR_N, 0, 32'h3C);

    // Disabled write is ignored
    wa1 = 4'd0; wd1 = 32'hDEAD;
    tick();
    set_rd(0, 4'd0);
    expect_v("we_low_ignored", S_DATA_N, 0, 32'h2);

    // Async reset between edges
    we1 = 1; wa1 = 4'd2; wd1 = 32'h7;
    lock_en = 1; lock_addr = 4'd2;
    set_rd(2, 4'd2);
    tick();
    expect_v("r2_before_rst", S_DATA_N, 2, 32'h7);
    expect_v("r2_busy_before_rst", S_BUSY_N, 2, 32'h1);
    @(negedge clk);
    drain();
    #2 reset = 1'b1;
    #1;
    expect_v("rst_async_r2", S_DATA_N, 2, 32'h0);
    expect_v("rst_async_pc", S_PC_N, 0, 32'h0);
    expect_v("rst_async_cspr", S_CSPR_B, 0, 32'h0);
    expect_v("rst_async_busy2", S_BUSY_N, 2, 32'h0);
    expect_v("rst_async_busy6", S_BUSY_B, 6, 32'h0);
    drain();
    #1 reset = 1'b0;

    // First edge after release takes a write
    we1 = 1; wa1 = 4'd4; wd1 = 32'h99;
    set_rd(3, 4'd4);
    @(posedge clk);
    #1 clear_inputs();
    expect_v("post_rst_write", S_DATA_N, 3, 32'h99);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
